// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: controller
// states, operand width and the MIPS func codes that reach this unit.
package mult_unit_pkg;

   localparam int WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam logic [5:0] MULT  = 6'h18;
   localparam logic [5:0] MULTU = 6'h19;
   localparam logic [5:0] MFHI  = 6'h10;
   localparam logic [5:0] MFLO  = 6'h12;

endpackage

// File: rtl/mult_unit.sv
// Sequential 32x32 multiplier for mult/multu. It multiplies magnitudes with
// one shift-add step per clock. The sign is applied to the full 64-bit
// product when hi/lo are written. hi/lo change only when a multiply completes.
module mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   import mult_unit_pkg::*;

   // Absolute value for signed operands. -0x80000000 wraps back to 0x80000000,
   // which is the correct magnitude when the result is read as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic use_sign);
      logic signed [WIDTH-1:0] neg;
      neg = -v;
      if (use_sign && v[WIDTH-1])
         return unsigned'(neg);
      else
         return unsigned'(v);
   endfunction

   // Two's-complement negation over all 64 bits, so the carry out of lo reaches hi.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic neg);
      logic signed [2*WIDTH-1:0] ps;
      logic signed [2*WIDTH-1:0] pn;
      ps = signed'(p);
      pn = -ps;
      if (neg)
         return unsigned'(pn);
      else
         return p;
   endfunction

   mult_state_t        state;
   mult_state_t        state_nxt;
   logic [4:0]         count;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   mcand;
   logic               res_neg;

   logic               accept;
   logic               last_step;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]   mplier_nxt;
   logic [2*WIDTH-1:0] product;

   // A request is taken in IDLE or DONE. While RUN is active, a request is ignored.
   assign accept    = start_mult && (state != RUN);
   assign last_step = (state == RUN) && (count == 5'd31);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

   // One shift-add step. The 33-bit sum keeps the carry, which shifts into acc's MSB.
   always_comb begin
      sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_nxt    = sum[WIDTH:1];
      mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
      product    = apply_sign({acc_nxt, mplier_nxt}, res_neg);
   end

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic. DONE lasts one cycle and accepts a new request like IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_mult) state_nxt = RUN;
         RUN:     if (count == 5'd31) state_nxt = DONE;
         DONE:    state_nxt = start_mult ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator, step counter and architectural hi/lo. hi/lo are written only on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (accept) begin
         acc   <= '0;
         count <= '0;
      end else if (state == RUN) begin
         acc   <= acc_nxt;
         count <= count + 5'd1;
         if (last_step) begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
         end
      end
   end

   // Operand registers. They are always loaded on accept before use, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand   <= magnitude(signed'(a), mult_sign);
         mplier  <= magnitude(signed'(b), mult_sign);
         res_neg <= (a[WIDTH-1] ^ b[WIDTH-1]) & mult_sign;
      end else if (state == RUN) begin
         mplier  <= mplier_nxt;
      end
   end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: reset state, signed/unsigned products,
// corner operands, ignored restarts, back-to-back issue and mid-run reset.
module tb_mult_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_mult;
   logic        mult_sign;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int          errors = 0;
   int          checks = 0;
   int          repulse_at = -1;
   logic [63:0] exp_hilo = 64'h0;

   mult_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge. The request is sampled at the following posedge.
   task automatic start_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
      start_mult = 1'b1;
      mult_sign  = sgn;
      a          = av;
      b          = bv;
      @(negedge clk);
      start_mult = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic sgn,
                                input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] ehi, input logic [31:0] elo,
                                input bit chk_fall);
      int cyc;
      start_op(sgn, av, bv);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         if (cyc == 16) check({tag, "_hold"}, {hi, lo}, exp_hilo);
         if (cyc == repulse_at) begin
            start_mult = 1'b1;
            mult_sign  = 1'b1;
            a          = 32'd7;
            b          = 32'd9;
         end else begin
            start_mult = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start_mult = 1'b0;
      check({tag, "_lat"}, 64'(cyc), 64'd32);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hilo"}, {hi, lo}, {ehi, elo});
      exp_hilo = {ehi, elo};
      if (chk_fall) begin
         @(negedge clk);
         check({tag, "_done_fall"}, 64'(done), 64'd0);
         check({tag, "_idle"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      logic seen;
      rst_n      = 1'b0;
      start_mult = 1'b0;
      mult_sign  = 1'b0;
      a          = '0;
      b          = '0;
      #3;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_and_check("u3x5",      1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 1'b1);
      run_and_check("s_m2x3",    1'b1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
      run_and_check("u_ffxff",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
      run_and_check("s_ffxff",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1);
      run_and_check("s_minxmin", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1);
      run_and_check("s_minx1",   1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      run_and_check("s_m5xm7",   1'b1, 32'hFFFFFFFB, 32'hFFFFFFF9, 32'h00000000, 32'h00000023, 1'b1);
      run_and_check("s_carry",   1'b1, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000, 1'b1);

      // A second request at cycle 10 must not disturb the multiply in flight.
      repulse_at = 9;
      run_and_check("ignore",    1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0);
      repulse_at = -1;

      // Issue while DONE is showing, with no idle cycle in between.
      run_and_check("b2b",       1'b0, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF, 1'b1);

      // Reset during cycle 15 of a multiply aborts it.
      start_op(1'b0, 32'h00001234, 32'h00001000);
      repeat (14) @(negedge clk);
      check("abort_busy_before", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      check("abort_hilo_kept", {hi, lo}, 64'd0);
      exp_hilo = 64'h0;
      run_and_check("u7x6",      1'b0, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; the implementation supports only 32.
REQ-002 The clk input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 The rst_n input, 1 bit, is an asynchronous, active-low reset.
REQ-004 The start_mult input, 1 bit, is the multiply request from the controller, sampled at the rising edge of clk.
REQ-005 The mult_sign input, 1 bit, selects the operation: 1 = signed (mult), 0 = unsigned (multu); sampled with start_mult.
REQ-006 The a input, WIDTH bits, is operand rs, sampled with start_mult.
REQ-007 The b input, WIDTH bits, is operand rt, sampled with start_mult.
REQ-008 The hi output, WIDTH bits, is the registered upper half of the last completed product (mfhi source).
REQ-009 The lo output, WIDTH bits, is the registered lower half of the last completed product (mflo source).
REQ-010 The busy output, 1 bit, is high while a multiply is in flight; the hazard unit stalls mfhi/mflo/mult on it.
REQ-011 The done output, 1 bit, is a one-cycle pulse in the cycle after hi/lo update.

Function
REQ-012 The state machine has three states: IDLE, RUN and DONE.
REQ-013 IDLE with start_mult=1 at edge E0: latch operand magnitudes (|a|, |b| if mult_sign=1, else raw), latch result sign = a[31]^b[31] & mult_sign, clear accumulator and count, go to RUN, busy=1.
REQ-014 RUN performs one shift-add iteration per edge (if multiplier LSB=1 add multiplicand to upper accumulator, then shift the 64-bit {acc,multiplier} right by 1, carry included).
REQ-015 After the 32nd RUN edge (E32), write hi/lo with the 64-bit product (two's-complement negated if result sign=1), go to DONE, busy=0.
REQ-016 DONE asserts done=1 for exactly one cycle, then goes to IDLE; start_mult seen in DONE is accepted exactly as in IDLE.
REQ-017 Latency: hi/lo valid 32 cycles after the start edge; throughput is one multiply per 33 cycles.
REQ-018 start_mult while busy=1 is ignored; operands, count and hi/lo are unaffected.
REQ-019 hi/lo hold their previous values throughout RUN; there are no partial results on the outputs.
REQ-020 Magnitude of 0x80000000 is 0x80000000 unsigned (33-bit-safe abs, no overflow).
REQ-021 The count is a 5-bit counter; RUN exits on count wrap from 31 to 0, with no extra cycle.
REQ-022 The 64-bit negation is performed on the full product; the carry from lo to hi propagates.

Reset
REQ-023 rst_n=0 asynchronously forces state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, accumulator=0.
REQ-024 Reset mid-RUN aborts the operation; no hi/lo update and no done pulse occurs; the first start after release behaves as from IDLE.

Structure
REQ-025 The shared package holds the state enum (IDLE/RUN/DONE), WIDTH=32, and the func codes MULT=6'h18, MULTU=6'h19, MFHI=6'h10 and MFLO=6'h12.
REQ-026 The block is one module with no sub-modules; the abs/negate logic is inline.

Verification
REQ-027 Unsigned 3*5: start E0 -> busy for 32 cycles, hi=0x00000000, lo=0x0000000F at E32, done pulse at E32..E33.
REQ-028 Signed -2*3 (0xFFFFFFFE, 0x00000003) -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed same operands -> hi=0, lo=1.
REQ-030 Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000; signed 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-031 start_mult re-pulsed at cycle 10 with different operands -> ignored; first result is returned at E32 unchanged.
REQ-032 rst_n low at cycle 15 of a multiply -> hi=lo=0, busy=0, no done; a new 7*6 afterwards -> lo=42, hi=0 after 32 cycles.
